// File: rtl/uart_tx_buffered_if.sv
// Write-side bus of the buffered UART transmitter: push handshake plus FIFO status.
// The producer takes the master modport; the transmitter takes the slave modport.
interface uart_tx_buffered_if #(
    parameter int PAYLOAD_BITS = 8,
    parameter int BUFFER_SIZE  = 8
);
    localparam int CW = $clog2(BUFFER_SIZE + 1);

    logic                    write_i;
    logic [PAYLOAD_BITS-1:0] data_i;
    logic                    full_o;
    logic                    empty_o;
    logic [CW-1:0]           count_o;
    logic                    overflow_o;

    modport master (
        output write_i,
        output data_i,
        input  full_o,
        input  empty_o,
        input  count_o,
        input  overflow_o
    );

    modport slave (
        input  write_i,
        input  data_i,
        output full_o,
        output empty_o,
        output count_o,
        output overflow_o
    );
endinterface

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: a power-of-two word FIFO feeding a start/data/parity/stop
// serialiser that chains frames back to back while words remain queued.
module uart_tx_buffered #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int BUFFER_SIZE  = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_buffered_if.slave   bus,
    output logic                busy_o,
    output logic                tx
);
    localparam int CPB    = CLK_FREQ / BIT_RATE;
    localparam int AW     = $clog2(BUFFER_SIZE);
    localparam int CW     = $clog2(BUFFER_SIZE + 1);
    localparam int BW     = $clog2(PAYLOAD_BITS);
    localparam int CNT_W  = $clog2(STOP_BITS * CPB);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_BITS * CPB - 1);
    localparam logic [BW-1:0]    DATA_LAST = BW'(PAYLOAD_BITS - 1);
    localparam logic [CW-1:0]    FULL_CNT  = CW'(BUFFER_SIZE);

    if (CPB < 2) begin : g_bad_cpb
        $error("uart_tx_buffered: CLK_FREQ/BIT_RATE must be at least 2");
    end
    if (PAYLOAD_BITS < 5 || PAYLOAD_BITS > 16) begin : g_bad_payload
        $error("uart_tx_buffered: PAYLOAD_BITS must be in 5..16");
    end
    if (BUFFER_SIZE < 2 || (BUFFER_SIZE & (BUFFER_SIZE - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_buffered: BUFFER_SIZE must be a power of two >= 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // Odd parity inverts the XOR so the total count of ones comes out odd.
    function automatic logic parity_of(input logic [PAYLOAD_BITS-1:0] w);
        return (PARITY == 1) ? ~(^w) : (^w);
    endfunction

    logic [PAYLOAD_BITS-1:0] mem [BUFFER_SIZE];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]           count_q, count_n;
    logic                    full_q, empty_q, overflow_q;
    logic                    push, pop;
    logic [PAYLOAD_BITS-1:0] head;

    state_t                  state_q, state_n;
    logic [CNT_W-1:0]        cnt_q, cnt_n;
    logic [BW-1:0]           bit_q, bit_n;
    logic [PAYLOAD_BITS-1:0] shreg_q, shreg_n;
    logic                    par_q, par_n;
    logic                    tx_q, tx_n;
    logic                    busy_q, busy_n;
    logic                    load;

    // Full is judged on the registered flag, so a push on a full FIFO is refused
    // even when the serialiser pops on the same edge.
    assign push = bus.write_i && !full_q;
    assign head = mem[rd_ptr_q];

    always_comb begin
        count_n = count_q;
        unique case ({push, pop})
            2'b10:   count_n = count_q + 1'b1;
            2'b01:   count_n = count_q - 1'b1;
            default: count_n = count_q;
        endcase
    end

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        bit_n   = bit_q;
        shreg_n = shreg_q;
        par_n   = par_q;
        tx_n    = tx_q;
        busy_n  = busy_q;
        load    = 1'b0;
        pop     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                load   = !empty_q;
            end
            S_START: begin
                if (cnt_q == '0) begin
                    state_n = S_DATA;
                    cnt_n   = BIT_LAST;
                    bit_n   = '0;
                    tx_n    = shreg_q[0];
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 1'b1;
                end else if (bit_q != DATA_LAST) begin
                    cnt_n   = BIT_LAST;
                    bit_n   = bit_q + 1'b1;
                    shreg_n = {1'b0, shreg_q[PAYLOAD_BITS-1:1]};
                    tx_n    = shreg_q[1];
                end else if (PARITY != 0) begin
                    state_n = S_PARITY;
                    cnt_n   = BIT_LAST;
                    tx_n    = par_q;
                end else begin
                    state_n = S_STOP;
                    cnt_n   = STOP_LAST;
                    tx_n    = 1'b1;
                end
            end
            S_PARITY: begin
                if (cnt_q == '0) begin
                    state_n = S_STOP;
                    cnt_n   = STOP_LAST;
                    tx_n    = 1'b1;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - 1'b1;
                end else if (!empty_q) begin
                    load = 1'b1;
                end else begin
                    state_n = S_IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase

        // Shared frame launch from IDLE and from the last stop cycle.
        if (load) begin
            pop     = 1'b1;
            shreg_n = head;
            par_n   = parity_of(head);
            tx_n    = 1'b0;
            busy_n  = 1'b1;
            state_n = S_START;
            cnt_n   = BIT_LAST;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_n;
            full_q     <= (count_n == FULL_CNT);
            empty_q    <= (count_n == '0);
            overflow_q <= bus.write_i && full_q;
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            bit_q      <= bit_n;
            tx_q       <= tx_n;
            busy_q     <= busy_n;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.data_i;
        shreg_q <= shreg_n;
        par_q   <= par_n;
    end

    assign bus.full_o     = full_q;
    assign bus.empty_o    = empty_q;
    assign bus.count_o    = count_q;
    assign bus.overflow_o = overflow_q;
    assign busy_o         = busy_q;
    assign tx             = tx_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench: four transmitter instances (8N1, 8E1, 8O1, 8N2) at four clocks per bit.
// Frame vectors are table-driven; FIFO, back-to-back and reset cases are written out.
module tb_uart_tx_buffered;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] wr  = '0;
    logic [7:0] din [4];
    wire  [3:0] tx_w;
    wire  [3:0] busy_w;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_buffered_if #(.PAYLOAD_BITS(8), .BUFFER_SIZE(8)) if_a ();
    uart_tx_buffered_if #(.PAYLOAD_BITS(8), .BUFFER_SIZE(8)) if_e ();
    uart_tx_buffered_if #(.PAYLOAD_BITS(8), .BUFFER_SIZE(8)) if_o ();
    uart_tx_buffered_if #(.PAYLOAD_BITS(8), .BUFFER_SIZE(8)) if_s ();

    assign if_a.write_i = wr[0];
    assign if_a.data_i  = din[0];
    assign if_e.write_i = wr[1];
    assign if_e.data_i  = din[1];
    assign if_o.write_i = wr[2];
    assign if_o.data_i  = din[2];
    assign if_s.write_i = wr[3];
    assign if_s.data_i  = din[3];

    uart_tx_buffered #(.CLK_FREQ(40), .BIT_RATE(10), .PAYLOAD_BITS(8), .BUFFER_SIZE(8),
                       .PARITY(0), .STOP_BITS(1))
        dut_a (.clk(clk), .rst(rst), .bus(if_a.slave), .busy_o(busy_w[0]), .tx(tx_w[0]));
    uart_tx_buffered #(.CLK_FREQ(40), .BIT_RATE(10), .PAYLOAD_BITS(8), .BUFFER_SIZE(8),
                       .PARITY(2), .STOP_BITS(1))
        dut_e (.clk(clk), .rst(rst), .bus(if_e.slave), .busy_o(busy_w[1]), .tx(tx_w[1]));
    uart_tx_buffered #(.CLK_FREQ(40), .BIT_RATE(10), .PAYLOAD_BITS(8), .BUFFER_SIZE(8),
                       .PARITY(1), .STOP_BITS(1))
        dut_o (.clk(clk), .rst(rst), .bus(if_o.slave), .busy_o(busy_w[2]), .tx(tx_w[2]));
    uart_tx_buffered #(.CLK_FREQ(40), .BIT_RATE(10), .PAYLOAD_BITS(8), .BUFFER_SIZE(8),
                       .PARITY(0), .STOP_BITS(2))
        dut_s (.clk(clk), .rst(rst), .bus(if_s.slave), .busy_o(busy_w[3]), .tx(tx_w[3]));

    typedef struct {
        int          dut;
        logic [7:0]  data;
        logic [15:0] frame;    // bit i = i-th bit on the line
        int          nbits;
        int          busy_cyc;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Call just after the edge that drove the start bit; returns 40 cycles later.
    task automatic recv_a(output logic [9:0] f);
        for (int b = 0; b < 10; b++) begin
            tick();
            tick();
            f[b] = tx_w[0];
            tick();
            tick();
        end
    endtask

    initial begin
        logic [15:0] rx;
        logic [9:0]  f;
        logic [7:0]  words [8];
        logic [21:0] wave;
        int          d, bcnt, errs, berrs;

        for (int i = 0; i < 4; i++) din[i] = 8'h00;

        vecs[0] = '{dut: 0, data: 8'hA5, frame: 16'(10'b1101001010),  nbits: 10, busy_cyc: 40};
        vecs[1] = '{dut: 1, data: 8'h07, frame: 16'(11'b11000001110), nbits: 11, busy_cyc: 44};
        vecs[2] = '{dut: 2, data: 8'h07, frame: 16'(11'b10000001110), nbits: 11, busy_cyc: 44};
        vecs[3] = '{dut: 0, data: 8'h3C, frame: 16'(10'b1001111000),  nbits: 10, busy_cyc: 40};
        vecs[4] = '{dut: 3, data: 8'h00, frame: 16'(11'b11000000000), nbits: 11, busy_cyc: 44};

        words[0] = 8'h81; words[1] = 8'h42; words[2] = 8'h24; words[3] = 8'h18;
        words[4] = 8'hC3; words[5] = 8'h3C; words[6] = 8'hE7; words[7] = 8'h7E;

        tick();
        tick();
        rst = 1'b0;
        check("reset_tx",       32'(tx_w[0]),          32'd1);
        check("reset_busy",     32'(busy_w[0]),        32'd0);
        check("reset_full",     32'(if_a.full_o),      32'd0);
        check("reset_empty",    32'(if_a.empty_o),     32'd1);
        check("reset_count",    32'(if_a.count_o),     32'd0);
        check("reset_overflow", 32'(if_a.overflow_o),  32'd0);
        check("reset_tx_8n2",   32'(tx_w[3]),          32'd1);

        for (int i = 0; i < 5; i++) begin
            d = vecs[i].dut;
            wr[d]  = 1'b1;
            din[d] = vecs[i].data;
            tick();
            wr[d] = 1'b0;
            tick();
            check($sformatf("vec%0d_start_latency", i), 32'(tx_w[d]), 32'd0);
            if (i == 0) check("vec0_empty_after_pop", 32'(if_a.empty_o), 32'd1);
            bcnt = busy_w[d] ? 1 : 0;
            rx   = '0;
            for (int c = 0; c < 4 * vecs[i].nbits; c++) begin
                tick();
                if (busy_w[d]) bcnt++;
                if (c % 4 == 1) rx[c / 4] = tx_w[d];
            end
            check($sformatf("vec%0d_frame", i), 32'(rx), 32'(vecs[i].frame));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].busy_cyc));
            check($sformatf("vec%0d_idle_tx", i), 32'(tx_w[d]), 32'd1);
        end

        // Two words on consecutive edges into the 8N2 instance: no idle gap.
        wave = {11'b11111111110, 11'b11000000000};
        wr[3]  = 1'b1;
        din[3] = 8'h00;
        tick();
        din[3] = 8'hFF;
        tick();
        wr[3] = 1'b0;
        errs  = 0;
        berrs = 0;
        for (int c = 0; c < 88; c++) begin
            if (tx_w[3] !== wave[c / 4]) errs++;
            if (busy_w[3] !== 1'b1) berrs++;
            if (c == 43) check("b2b_last_stop_high", 32'(tx_w[3]), 32'd1);
            if (c == 44) check("b2b_second_start_at_44", 32'(tx_w[3]), 32'd0);
            tick();
        end
        check("b2b_waveform_errors", 32'(errs), 32'd0);
        check("b2b_busy_gaps", 32'(berrs), 32'd0);
        check("b2b_idle_busy", 32'(busy_w[3]), 32'd0);

        // Fill while busy, overflow, then a refused write on the pop edge.
        wr[0]  = 1'b1;
        din[0] = 8'h55;
        tick();
        for (int k = 0; k < 8; k++) begin
            din[0] = words[k];
            tick();
            if (k == 0) check("fifo_push_pop_count", 32'(if_a.count_o), 32'd1);
        end
        check("fifo_full_after_8", 32'(if_a.full_o), 32'd1);
        check("fifo_count_8", 32'(if_a.count_o), 32'd8);
        check("fifo_no_overflow_yet", 32'(if_a.overflow_o), 32'd0);
        din[0] = 8'hEE;
        tick();
        wr[0] = 1'b0;
        check("overflow_pulse", 32'(if_a.overflow_o), 32'd1);
        check("overflow_count_kept", 32'(if_a.count_o), 32'd8);
        tick();
        check("overflow_one_cycle", 32'(if_a.overflow_o), 32'd0);
        for (int k = 0; k < 30; k++) tick();
        check("pre_pop_full", 32'(if_a.full_o), 32'd1);
        wr[0]  = 1'b1;
        din[0] = 8'hFF;
        tick();
        wr[0] = 1'b0;
        check("pop_edge_count_7", 32'(if_a.count_o), 32'd7);
        check("pop_edge_overflow", 32'(if_a.overflow_o), 32'd1);
        check("pop_edge_full_clear", 32'(if_a.full_o), 32'd0);
        check("pop_edge_next_start", 32'(tx_w[0]), 32'd0);
        check("pop_edge_busy", 32'(busy_w[0]), 32'd1);
        for (int k = 0; k < 8; k++) begin
            recv_a(f);
            check($sformatf("fifo_order_word%0d", k), 32'(f), 32'({1'b1, words[k], 1'b0}));
        end
        check("drain_busy", 32'(busy_w[0]), 32'd0);
        check("drain_tx", 32'(tx_w[0]), 32'd1);
        check("drain_empty", 32'(if_a.empty_o), 32'd1);

        // Reset in the middle of a DATA bit with three words queued.
        wr[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din[0] = 8'h10 + 8'(k);
            tick();
        end
        wr[0] = 1'b0;
        check("rst_pre_count", 32'(if_a.count_o), 32'd3);
        for (int k = 0; k < 7; k++) tick();
        check("rst_pre_busy", 32'(busy_w[0]), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_tx", 32'(tx_w[0]), 32'd1);
        check("rst_mid_busy", 32'(busy_w[0]), 32'd0);
        check("rst_mid_count", 32'(if_a.count_o), 32'd0);
        check("rst_mid_empty", 32'(if_a.empty_o), 32'd1);
        errs = 0;
        for (int k = 0; k < 60; k++) begin
            tick();
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) errs++;
        end
        check("rst_no_further_frames", 32'(errs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Parametrised successor to the controller's UART transmit path.
- Buffers outgoing words in a configurable FIFO and serialises them on `tx`.
- Configurable payload width, parity mode and stop-bit count; sustains back-to-back frames with no idle gap.
- Sits between the controller's response logic and the host serial line; also usable standalone in core wrappers.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz
- BIT_RATE, 115200, serial bit rate in baud
- PAYLOAD_BITS, 8, data bits per frame (5..16)
- BUFFER_SIZE, 8, FIFO depth in words (power of 2, >=2)
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even
- STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- write_i  input  1  push request; data_i sampled when high
- data_i  input  PAYLOAD_BITS  word to transmit
- full_o  output  1  FIFO holds BUFFER_SIZE words
- empty_o  output  1  FIFO holds 0 words
- count_o  output  $clog2(BUFFER_SIZE+1)  words currently buffered (excludes word in shifter)
- overflow_o  output  1  one-cycle pulse: write_i while full_o
- busy_o  output  1  frame in progress (START..STOP)
- tx  output  1  serial line, idle high

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values: tx=1, busy_o=0, full_o=0, empty_o=1, count_o=0, overflow_o=0, FSM=IDLE, FIFO pointers=0.
- Reset mid-frame: tx=1 from the cycle after the reset edge; buffered words and the shifter are discarded.
- CPB = CLK_FREQ/BIT_RATE (integer division). Elaboration error if CPB<2.
- Each bit holds tx for exactly CPB cycles; the baud counter reloads at every bit boundary.
- FIFO write: on an edge with write_i=1 and full_o=0, data_i is stored and count increments.
- FIFO overflow: write_i=1 while full_o=1 drops the word, leaves FIFO unchanged, and raises overflow_o for that following cycle only.
- full_o, empty_o and count_o are registered and reflect state after each edge.
- Simultaneous write and pop:
  - full FIFO: write rejected because full_o is evaluated before the pop; count drops by 1.
  - otherwise: both occur and count is unchanged.
- Pointers wrap modulo BUFFER_SIZE.
- FSM states IDLE, START, DATA, PARITY, STOP:
  - IDLE: tx=1, busy_o=0. If empty_o=0 at an edge: pop head into shifter, tx<=0, busy_o<=1, go to START. A word written at edge N therefore drives tx low at edge N+1.
  - START: tx=0 for CPB cycles, then DATA.
  - DATA: PAYLOAD_BITS bits, LSB first, CPB cycles each. Then PARITY if PARITY!=0, else STOP.
  - PARITY: tx = XOR of data bits (even) or its inverse (odd), CPB cycles.
  - STOP: tx=1 for STOP_BITS*CPB cycles.
- Last STOP cycle:
  - FIFO non-empty: pop and enter START directly (tx falls on the next edge, busy_o stays 1).
  - FIFO empty: go to IDLE.
- Frame length is exactly (1+PAYLOAD_BITS+(PARITY!=0)+STOP_BITS)*CPB cycles.
- Word width: data_i is stored unmodified; no truncation or extension.

Test Plan (CLK_FREQ=40, BIT_RATE=10 gives CPB=4):
- Reset, then write 0xA5 once (8N1) -> tx low one cycle after the write edge. Sequence held 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1. busy_o high for 40 cycles. empty_o=1 after the pop.
- PARITY=2, write 0x07 -> parity bit 1. PARITY=1, same word -> parity bit 0. Frame is 44 cycles.
- STOP_BITS=2, write 0x00 then 0xFF on consecutive cycles -> second start bit begins exactly 44 cycles after the first. No idle gap; busy_o stays high throughout.
- Write 9 words while busy with BUFFER_SIZE=8:
  - full_o=1 after the 8th accepted write (count_o=8).
  - The 9th write is dropped and overflow_o pulses exactly 1 cycle.
  - The 8 buffered words are transmitted in write order.
- With a full FIFO, assert write_i on the same edge as a pop -> write rejected, count_o=7, overflow_o pulses.
- Assert rst during the DATA state of a frame with 3 words queued -> tx=1, count_o=0, empty_o=1, busy_o=0 one cycle later. No further frames until a new write.
